// File: rtl/rvjtag_pkg.sv
// Shared types and constants for the rvjtag_master JTAG/DMI initiator.
package rvjtag_pkg;

   typedef enum logic [1:0] {
      DMI_READ  = 2'd0,
      DMI_WRITE = 2'd1,
      DTMCS     = 2'd2,
      IDCODE    = 2'd3
   } op_e;

   localparam logic [4:0] IR_IDCODE = 5'h01;
   localparam logic [4:0] IR_DTMCS  = 5'h10;
   localparam logic [4:0] IR_DMI    = 5'h11;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_RD  = 2'b01;
   localparam logic [1:0] OP_WR  = 2'b10;

   typedef enum logic [3:0] {
      RESET_SEQ,
      IDLE,
      IR_HDR,
      IR_SHIFT,
      IR_TAIL,
      DR_HDR,
      DR_SHIFT,
      DR_TAIL,
      RTI_WAIT,
      RESP
   } state_e;

   function automatic logic is_dmi(input op_e op);
      return (op == DMI_READ) || (op == DMI_WRITE);
   endfunction

   function automatic logic [4:0] ir_for(input op_e op);
      logic [4:0] ir;
      case (op)
         DMI_READ, DMI_WRITE: ir = IR_DMI;
         DTMCS:               ir = IR_DTMCS;
         default:             ir = IR_IDCODE;
      endcase
      return ir;
   endfunction

endpackage

// File: rtl/rvjtag_master_tck_gen.sv
// tck divider: CLK_DIV clk low then CLK_DIV clk high, with strobes marking
// the clk on which tck rises or falls. Held low while not enabled.
module rvjtag_master_tck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic trst,
   input  logic en,
   output logic tck,
   output logic rise,
   output logic fall
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tck_q, tck_d;
   logic          wrap;

   assign wrap = (cnt_q == CNT_LAST);
   assign rise = en && wrap && !tck_q;
   assign fall = en && wrap && tck_q;
   assign tck  = tck_q;

   always_comb begin
      cnt_d = cnt_q;
      tck_d = tck_q;
      if (!en) begin
         cnt_d = '0;
         tck_d = 1'b0;
      end else if (wrap) begin
         cnt_d = '0;
         tck_d = ~tck_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge trst) begin
      if (!trst) begin
         cnt_q <= '0;
         tck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tck_q <= tck_d;
      end
   end

endmodule

// File: rtl/rvjtag_master.sv
// JTAG initiator: turns one request into IR/DR scans against a DMI TAP,
// always starting and ending in Run-Test/Idle.
module rvjtag_master
   import rvjtag_pkg::*;
#(
   parameter int AWIDTH     = 7,
   parameter int CLK_DIV    = 2,
   parameter int RTI_CYCLES = 4
) (
   input  logic              clk,
   input  logic              trst,
   output logic              tck,
   output logic              tms,
   output logic              tdi,
   input  logic              tdo,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [31:0]       req_data,
   output logic              resp_valid,
   output logic [31:0]       resp_data,
   output logic [1:0]        resp_status,
   output logic              busy,
   output state_e            dbg_state
);

   localparam int DR_W = AWIDTH + 34;
   localparam logic [5:0] DMI_LAST = 6'(DR_W - 1);
   localparam logic [5:0] CSR_LAST = 6'd31;
   localparam logic [5:0] RTI_LAST = 6'(RTI_CYCLES - 1);

   state_e            state_q, state_d;
   logic [5:0]        bit_cnt_q, bit_cnt_d;
   logic              tms_q, tms_d;
   logic              tdi_q, tdi_d;
   logic [4:0]        ir_cache_q, ir_cache_d;
   logic [DR_W-1:0]   dr_out_q, dr_out_d;
   logic [33:0]       cap_q, cap_d;
   op_e               op_q, op_d;
   logic              second_q, second_d;
   logic              busy_q, busy_d;
   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       resp_data_q, resp_data_d;
   logic [1:0]        resp_status_q, resp_status_d;

   logic       tck_en, tck_rise, tck_fall;
   logic [5:0] nxt;
   logic [5:0] dr_last;
   logic [4:0] ir_req;
   op_e        req_op_e;

   rvjtag_master_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
      .clk  (clk),
      .trst (trst),
      .en   (tck_en),
      .tck  (tck),
      .rise (tck_rise),
      .fall (tck_fall)
   );

   assign tck_en   = (state_q != IDLE) && (state_q != RESP);
   assign nxt      = bit_cnt_q + 6'd1;
   assign dr_last  = is_dmi(op_q) ? DMI_LAST : CSR_LAST;
   assign ir_req   = ir_for(op_q);
   assign req_op_e = op_e'(req_op);

   // Every state advances on the tck falling strobe, which is also when
   // tms/tdi for the following tck cycle are loaded.
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      tms_d         = tms_q;
      tdi_d         = tdi_q;
      ir_cache_d    = ir_cache_q;
      dr_out_d      = dr_out_q;
      cap_d         = cap_q;
      op_d          = op_q;
      second_d      = second_q;
      busy_d        = busy_q;
      req_ready_d   = req_ready_q;
      resp_valid_d  = 1'b0;
      resp_data_d   = resp_data_q;
      resp_status_d = resp_status_q;

      if (tck_rise && (state_q == DR_SHIFT) && (bit_cnt_q < 6'd34)) begin
         cap_d[bit_cnt_q] = tdo;
      end

      case (state_q)
         RESET_SEQ: if (tck_fall) begin
            if (bit_cnt_q == 6'd5) begin
               state_d     = IDLE;
               bit_cnt_d   = '0;
               tms_d       = 1'b0;
               busy_d      = 1'b0;
               req_ready_d = 1'b1;
            end else begin
               bit_cnt_d = nxt;
               tms_d     = (bit_cnt_q != 6'd4);
            end
         end
         IDLE: if (req_valid && req_ready_q) begin
            op_d        = req_op_e;
            second_d    = 1'b0;
            busy_d      = 1'b1;
            req_ready_d = 1'b0;
            bit_cnt_d   = '0;
            tms_d       = 1'b1;
            tdi_d       = 1'b0;
            case (req_op_e)
               DMI_WRITE: dr_out_d = {req_addr, req_data, OP_WR};
               DMI_READ:  dr_out_d = {req_addr, 32'h0, OP_RD};
               DTMCS:     dr_out_d = DR_W'(req_data);
               default:   dr_out_d = '0;
            endcase
            state_d = (ir_cache_q == ir_for(req_op_e)) ? DR_HDR : IR_HDR;
         end
         IR_HDR: if (tck_fall) begin
            if (bit_cnt_q == 6'd3) begin
               state_d   = IR_SHIFT;
               bit_cnt_d = '0;
               tms_d     = 1'b0;
               tdi_d     = ir_req[0];
            end else begin
               bit_cnt_d = nxt;
               tms_d     = (bit_cnt_q == 6'd0);
            end
         end
         IR_SHIFT: if (tck_fall) begin
            if (bit_cnt_q == 6'd4) begin
               state_d   = IR_TAIL;
               bit_cnt_d = '0;
               tms_d     = 1'b1;
               tdi_d     = 1'b0;
            end else begin
               bit_cnt_d = nxt;
               tdi_d     = ir_req[nxt[2:0]];
               tms_d     = (nxt == 6'd4);
            end
         end
         IR_TAIL: if (tck_fall) begin
            if (bit_cnt_q == 6'd0) begin
               ir_cache_d = ir_req;
               bit_cnt_d  = 6'd1;
               tms_d      = 1'b0;
            end else begin
               state_d   = DR_HDR;
               bit_cnt_d = '0;
               tms_d     = 1'b1;
            end
         end
         DR_HDR: if (tck_fall) begin
            bit_cnt_d = (bit_cnt_q == 6'd2) ? 6'd0 : nxt;
            tms_d     = 1'b0;
            if (bit_cnt_q == 6'd2) begin
               state_d = DR_SHIFT;
               tdi_d   = dr_out_q[0];
            end
         end
         DR_SHIFT: if (tck_fall) begin
            if (bit_cnt_q == dr_last) begin
               state_d   = DR_TAIL;
               bit_cnt_d = '0;
               tms_d     = 1'b1;
               tdi_d     = 1'b0;
            end else begin
               bit_cnt_d = nxt;
               tdi_d     = dr_out_q[nxt];
               tms_d     = (nxt == dr_last);
            end
         end
         DR_TAIL: if (tck_fall) begin
            tms_d = 1'b0;
            if (bit_cnt_q == 6'd0) begin
               bit_cnt_d = 6'd1;
            end else begin
               state_d   = RTI_WAIT;
               bit_cnt_d = '0;
            end
         end
         RTI_WAIT: if (tck_fall) begin
            if (bit_cnt_q != RTI_LAST) begin
               bit_cnt_d = nxt;
            end else if ((op_q == DMI_READ) && !second_q) begin
               // Second pass of a read: NOP scan collects the read result.
               second_d  = 1'b1;
               dr_out_d  = '0;
               state_d   = DR_HDR;
               bit_cnt_d = '0;
               tms_d     = 1'b1;
            end else begin
               state_d       = RESP;
               bit_cnt_d     = '0;
               resp_valid_d  = 1'b1;
               resp_data_d   = is_dmi(op_q) ? cap_q[33:2] : cap_q[31:0];
               resp_status_d = is_dmi(op_q) ? cap_q[1:0] : 2'b00;
            end
         end
         RESP: begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            req_ready_d = 1'b1;
         end
         default: state_d = RESET_SEQ;
      endcase
   end

   always_ff @(posedge clk or negedge trst) begin
      if (!trst) begin
         state_q       <= RESET_SEQ;
         bit_cnt_q     <= '0;
         tms_q         <= 1'b1;
         tdi_q         <= 1'b0;
         ir_cache_q    <= IR_IDCODE;
         dr_out_q      <= '0;
         cap_q         <= '0;
         op_q          <= IDCODE;
         second_q      <= 1'b0;
         busy_q        <= 1'b1;
         req_ready_q   <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_data_q   <= '0;
         resp_status_q <= '0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         tms_q         <= tms_d;
         tdi_q         <= tdi_d;
         ir_cache_q    <= ir_cache_d;
         dr_out_q      <= dr_out_d;
         cap_q         <= cap_d;
         op_q          <= op_d;
         second_q      <= second_d;
         busy_q        <= busy_d;
         req_ready_q   <= req_ready_d;
         resp_valid_q  <= resp_valid_d;
         resp_data_q   <= resp_data_d;
         resp_status_q <= resp_status_d;
      end
   end

   assign tms         = tms_q;
   assign tdi         = tdi_q;
   assign req_ready   = req_ready_q;
   assign resp_valid  = resp_valid_q;
   assign resp_data   = resp_data_q;
   assign resp_status = resp_status_q;
   assign busy        = busy_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_rvjtag_master.sv
// Bench for rvjtag_master: behavioural DMI TAP on the JTAG pins and a
// response scoreboard fed with expected {status, data} per request.
module tb_rvjtag_master;
   import rvjtag_pkg::*;

   // Handshake: a request transfers on the clk edge where req_valid and
   // req_ready are both high; resp_valid is a single-clk pulse.

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic trst = 1'b0;
   always #5 clk = ~clk;

   logic        tck, tms, tdi, tdo;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'd0;
   logic [6:0]  req_addr = '0;
   logic [31:0] req_data = '0;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [1:0]  resp_status;
   logic        busy;
   state_e      dbg_state;

   rvjtag_master #(.AWIDTH(7), .CLK_DIV(2), .RTI_CYCLES(4)) dut (
      .clk(clk), .trst(trst), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_data(req_data), .resp_valid(resp_valid),
      .resp_data(resp_data), .resp_status(resp_status), .busy(busy),
      .dbg_state(dbg_state)
   );

   // ---------------- TAP model ----------------
   typedef enum logic [3:0] {
      T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR, T_UPDDR,
      T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPDIR
   } tap_e;

   localparam logic [30:0] JTAG_ID   = 31'h0000_0A2B;
   localparam logic [31:0] DTMCS_VAL = {14'h0, 2'b00, 1'b0, 3'd1, 2'd0, 6'd7, 4'd1};

   tap_e        tap_st = T_TLR;
   logic [4:0]  tap_ir = 5'h01;
   logic [63:0] tap_sr = '0;
   logic        tap_tdo = 1'b0;
   logic [31:0] dmi_result = '0;
   logic [1:0]  dmi_status = '0;
   int          dr_bits = 0;
   int          ir_upd_cnt = 0, wr_cnt = 0, rd_cnt = 0, dmi_reset_cnt = 0;
   logic [6:0]  wr_addr_seen = '0, rd_addr_seen = '0;
   logic [31:0] wr_data_seen = '0;
   logic [1:0]  last_op_seen = 2'b11;
   logic [31:0] tb_rd_data = '0;
   logic [1:0]  tb_rd_status = '0;

   assign tdo = tap_tdo;

   function automatic tap_e tap_next(input tap_e s, input logic m);
      case (s)
         T_TLR:   return m ? T_TLR   : T_RTI;
         T_RTI:   return m ? T_SELDR : T_RTI;
         T_SELDR: return m ? T_SELIR : T_CAPDR;
         T_CAPDR: return m ? T_EX1DR : T_SHDR;
         T_SHDR:  return m ? T_EX1DR : T_SHDR;
         T_EX1DR: return m ? T_UPDDR : T_PADR;
         T_PADR:  return m ? T_EX2DR : T_PADR;
         T_EX2DR: return m ? T_UPDDR : T_SHDR;
         T_UPDDR: return m ? T_SELDR : T_RTI;
         T_SELIR: return m ? T_TLR   : T_CAPIR;
         T_CAPIR: return m ? T_EX1IR : T_SHIR;
         T_SHIR:  return m ? T_EX1IR : T_SHIR;
         T_EX1IR: return m ? T_UPDIR : T_PAIR;
         T_PAIR:  return m ? T_EX2IR : T_PAIR;
         T_EX2IR: return m ? T_UPDIR : T_SHIR;
         default: return m ? T_SELDR : T_RTI;
      endcase
   endfunction

   function automatic int dr_len(input logic [4:0] ir);
      case (ir)
         5'h11:        return 41;
         5'h10, 5'h01: return 32;
         default:      return 1;
      endcase
   endfunction

   always @(posedge tck) begin
      case (tap_st)
         T_TLR: tap_ir <= 5'h01;
         T_CAPDR: begin
            dr_bits <= 0;
            case (tap_ir)
               5'h01:   tap_sr <= {32'h0, JTAG_ID, 1'b1};
               5'h10:   tap_sr <= {32'h0, DTMCS_VAL};
               5'h11:   tap_sr <= {30'h0, dmi_result, dmi_status};
               default: tap_sr <= '0;
            endcase
         end
         T_SHDR: begin
            tap_sr  <= (tap_sr >> 1) | (64'(tdi) << (dr_len(tap_ir) - 1));
            dr_bits <= dr_bits + 1;
         end
         T_UPDDR: begin
            if (tap_ir == 5'h11) begin
               last_op_seen <= tap_sr[1:0];
               if (tap_sr[1:0] == 2'b01) begin
                  rd_cnt       <= rd_cnt + 1;
                  rd_addr_seen <= tap_sr[40:34];
                  dmi_result   <= tb_rd_data;
                  dmi_status   <= tb_rd_status;
               end else if (tap_sr[1:0] == 2'b10) begin
                  wr_cnt       <= wr_cnt + 1;
                  wr_addr_seen <= tap_sr[40:34];
                  wr_data_seen <= tap_sr[33:2];
               end
            end else if ((tap_ir == 5'h10) && tap_sr[16]) begin
               dmi_reset_cnt <= dmi_reset_cnt + 1;
            end
         end
         T_CAPIR: tap_sr <= 64'h1;
         T_SHIR:  tap_sr <= (tap_sr >> 1) | (64'(tdi) << 4);
         T_UPDIR: begin
            tap_ir     <= tap_sr[4:0];
            ir_upd_cnt <= ir_upd_cnt + 1;
         end
         default: ;
      endcase
      tap_st <= tap_next(tap_st, tms);
   end

   always @(negedge tck) tap_tdo <= tap_sr[0];

   int tck_cnt = 0;
   always @(posedge tck) tck_cnt <= tck_cnt + 1;

   // ---------------- checking / scoreboard ----------------
   int vec_cnt = 0;
   int err_cnt = 0;
   int resp_cnt = 0;
   logic [33:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (resp_valid) begin
         logic [33:0] e;
         resp_cnt++;
         if (exp_q.size() == 0) begin
            check_eq("resp_unexpected", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("resp_data", resp_data, e[31:0]);
            check_eq("resp_status", resp_status, e[33:32]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_eq("ready_wait", req_ready, 1'b1);
   endtask

   task automatic run_req(input op_e op, input logic [6:0] addr, input logic [31:0] data,
                          input logic [33:0] exp, input int exp_tck, input bit hold);
      int t0, n, acc;
      wait_ready();
      exp_q.push_back(exp);
      t0 = tck_cnt;
      req_op = op;
      req_addr = addr;
      req_data = data;
      req_valid = 1'b1;
      acc = 1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!hold) req_valid = 1'b0;
         else if (!resp_valid && req_ready) acc++;
      end while (!resp_valid && n < 5000);
      check_eq("resp_seen", resp_valid, 1'b1);
      check_eq("ready_at_resp", req_ready, 1'b0);
      @(negedge clk);
      check_eq("ready_after_resp", req_ready, 1'b1);
      check_eq("busy_after_resp", busy, 1'b0);
      req_valid = 1'b0;
      if (hold) check_eq("accept_count", acc, 1);
      check_eq("tck_count", tck_cnt - t0, exp_tck);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int t0, r0, n, w0, rd0, dr0, ir0;
      logic [31:0] wdat, rdat;
      logic [6:0]  raddr;

      repeat (3) @(negedge clk);
      check_eq("rst_tck", tck, 1'b0);
      check_eq("rst_tms", tms, 1'b1);
      check_eq("rst_tdi", tdi, 1'b0);
      check_eq("rst_ready", req_ready, 1'b0);
      check_eq("rst_resp_valid", resp_valid, 1'b0);
      check_eq("rst_resp_data", resp_data, 32'h0);
      check_eq("rst_resp_status", resp_status, 2'b00);
      check_eq("rst_busy", busy, 1'b1);

      t0 = tck_cnt;
      trst = 1'b1;
      wait_ready();
      check_eq("rstseq_tck", tck_cnt - t0, 6);
      check_eq("rstseq_busy", busy, 1'b0);
      check_eq("rstseq_tap_rti", tap_st, T_RTI);

      // IDCODE with IR cache hit
      ir0 = ir_upd_cnt;
      run_req(IDCODE, 7'h0, 32'h0, {2'b00, 32'h0000_1457}, 41, 1'b0);
      check_eq("idcode_no_ir", ir_upd_cnt - ir0, 0);

      // two DMI writes, the second reuses the DMI IR
      w0 = wr_cnt;
      run_req(DMI_WRITE, 7'h10, 32'hDEAD_BEEF, {2'b00, 32'h0}, 61, 1'b0);
      check_eq("wr1_count", wr_cnt - w0, 1);
      check_eq("wr1_addr", wr_addr_seen, 7'h10);
      check_eq("wr1_data", wr_data_seen, 32'hDEAD_BEEF);
      wdat = $urandom;
      run_req(DMI_WRITE, 7'h12, wdat, {2'b00, 32'h0}, 50, 1'b0);
      check_eq("wr2_count", wr_cnt - w0, 2);
      check_eq("wr2_addr", wr_addr_seen, 7'h12);
      check_eq("wr2_data", wr_data_seen, wdat);

      // DMI read with req_valid held throughout
      tb_rd_data = 32'h1234_5678;
      tb_rd_status = 2'b00;
      rd0 = rd_cnt;
      run_req(DMI_READ, 7'h11, 32'h0, {2'b00, 32'h1234_5678}, 100, 1'b1);
      check_eq("rd1_count", rd_cnt - rd0, 1);
      check_eq("rd1_addr", rd_addr_seen, 7'h11);
      check_eq("rd1_second_op", last_op_seen, 2'b00);

      // DMI read with error status
      rdat = $urandom;
      raddr = 7'($urandom_range(0, 127));
      tb_rd_data = rdat;
      tb_rd_status = 2'b10;
      run_req(DMI_READ, raddr, 32'h0, {2'b10, rdat}, 100, 1'b0);
      check_eq("rd2_count", rd_cnt - rd0, 2);
      check_eq("rd2_addr", rd_addr_seen, raddr);

      // DTMCS: dmireset then plain access (IR cached)
      dr0 = dmi_reset_cnt;
      run_req(DTMCS, 7'h0, 32'h0001_0000, {2'b00, 32'h0000_1071}, 52, 1'b0);
      check_eq("dtmcs_dmireset", dmi_reset_cnt - dr0, 1);
      run_req(DTMCS, 7'h0, 32'h0, {2'b00, 32'h0000_1071}, 41, 1'b0);
      check_eq("dtmcs_no_dmireset", dmi_reset_cnt - dr0, 1);

      // trst during the 20th DR shift bit of a write
      wait_ready();
      r0 = resp_cnt;
      req_op = DMI_WRITE;
      req_addr = 7'h22;
      req_data = 32'hCAFE_F00D;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!(tap_st == T_SHDR && dr_bits == 19) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check_eq("abort_point_reached", (n < 3000), 1'b1);
      trst = 1'b0;
      #1;
      check_eq("abort_tck", tck, 1'b0);
      check_eq("abort_tms", tms, 1'b1);
      check_eq("abort_ready", req_ready, 1'b0);
      check_eq("abort_busy", busy, 1'b1);
      repeat (4) @(negedge clk);
      check_eq("abort_tck_held", tck, 1'b0);
      t0 = tck_cnt;
      trst = 1'b1;
      wait_ready();
      check_eq("abort_rstseq_tck", tck_cnt - t0, 6);
      check_eq("abort_no_resp", resp_cnt - r0, 0);
      check_eq("abort_tap_rti", tap_st, T_RTI);

      // IR cache is back to IDCODE after the rerun reset sequence
      ir0 = ir_upd_cnt;
      run_req(IDCODE, 7'h0, 32'h0, {2'b00, 32'h0000_1457}, 41, 1'b0);
      check_eq("idcode2_no_ir", ir_upd_cnt - ir0, 0);

      repeat (4) @(negedge clk);
      check_eq("exp_q_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
